// File: rtl/axi_req_scheduler.sv
// axi_req_scheduler: round-robin arbiter that feeds one transaction at a time to an AXI master.
// Optional WAIT-state watchdog is compiled in when SCHED_TIMEOUT_EN is defined.
module axi_req_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         start_read,
    output logic                         start_write,
    output logic [ADDR_W-1:0]            txn_addr,
    input  logic                         txn_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         timeout_err,
    output logic [1:0]                   state_dbg
);

    // Handshake: req_valid[i] is held by requester i until it sees the one-cycle req_ready[i]
    // pulse; a requester that drops req_valid before that simply forfeits its turn.
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("axi_req_scheduler: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ADDR_W-1:0]  txn_addr_q, txn_addr_d;
    logic               write_q, write_d;
    logic               hold_q, hold_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               start_read_q, start_read_d;
    logic               start_write_q, start_write_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  win_addr;
    logic               win_write;
    int                 scan_idx;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             wd_term;
    assign wd_term = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

    // Round-robin search starting just above the last completed grant.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_addr  = '0;
        win_write = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
                win_addr  = req_addr[scan_idx*ADDR_W +: ADDR_W];
                win_write = req_write[scan_idx];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        txn_addr_d    = txn_addr_q;
        write_d       = write_q;
        hold_d        = 1'b0;
        req_ready_d   = '0;
        start_read_d  = 1'b0;
        start_write_d = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // The first IDLE cycle after a completion never grants, so accepts are >= 4 cycles apart.
                if (win_found && !hold_q) begin
                    req_ready_d[win_id] = 1'b1;
                    txn_addr_d          = win_addr;
                    write_d             = win_write;
                    grant_id_d          = win_id;
                    state_d             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_write_d = write_q;
                start_read_d  = !write_q;
                state_d       = S_WAIT;
`ifdef SCHED_TIMEOUT_EN
                wd_cnt_d      = '0;
`endif
            end
            S_WAIT: begin
                if (txn_done) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = grant_id_q;
                    hold_d   = 1'b1;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (wd_term) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                    rr_ptr_d      = grant_id_q;
                    hold_d        = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            txn_addr_q    <= '0;
            write_q       <= 1'b0;
            hold_q        <= 1'b0;
            req_ready_q   <= '0;
            start_read_q  <= 1'b0;
            start_write_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            txn_addr_q    <= txn_addr_d;
            write_q       <= write_d;
            hold_q        <= hold_d;
            req_ready_q   <= req_ready_d;
            start_read_q  <= start_read_d;
            start_write_q <= start_write_d;
            busy_q        <= busy_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ready   = req_ready_q;
    assign start_read  = start_read_q;
    assign start_write = start_write_q;
    assign txn_addr    = txn_addr_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_axi_req_scheduler.sv
// tb_axi_req_scheduler: directed scenarios plus randomized transactions for axi_req_scheduler,
// checked against a transaction-level round-robin model.
module tb_axi_req_scheduler;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [3:0]   req_ready;
  logic         start_read;
  logic         start_write;
  logic [31:0]  txn_addr;
  logic         txn_done;
  logic         busy;
  logic [1:0]   grant_id;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: last completed grant, and what the current grant should carry.
  int          exp_ptr;
  int          exp_w;
  logic [31:0] exp_addr;
  logic        exp_write;
  logic [31:0] exp_q[$];

  // Observations captured at the grant / start cycles for directed follow-up checks.
  logic [31:0] obs_gid;
  logic [31:0] obs_addr;
  logic [31:0] obs_sw;
  logic [31:0] obs_sr;

  axi_req_scheduler #(
    .NUM_REQ     (4),
    .ADDR_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .start_read  (start_read),
    .start_write (start_write),
    .txn_addr    (txn_addr),
    .txn_done    (txn_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round robin: first valid index above the pointer, otherwise the lowest valid index.
  function automatic int rr_pick(input logic [3:0] m, input int ptr);
    for (int i = ptr + 1; i < 4; i++) if (m[i]) return i;
    for (int i = 0; i <= ptr; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_start_rd"}, 32'(start_read), 32'h0);
    chk({tag, "_start_wr"}, 32'(start_write), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'h0);
    chk({tag, "_addr"}, txn_addr, 32'h0);
    chk({tag, "_gid"}, 32'(grant_id), 32'h0);
  endtask

  // Starts in IDLE at a sample point; ends at the first WAIT cycle (start pulse visible).
  task automatic grant_phase(input logic [3:0] vmask, input logic [3:0] wvec, input bit hold,
                             input bit idle_done, input bit issue_done, input bit churn);
    req_valid = vmask;
    req_write = wvec;
    exp_w     = rr_pick(vmask, exp_ptr);
    exp_addr  = req_addr[exp_w*32 +: 32];
    exp_write = wvec[exp_w];
    if (hold) begin
      txn_done = idle_done;
      step();
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_busy", 32'(busy), 32'h0);
      chk("hold_timeout", 32'(timeout_err), 32'h0);
      txn_done = 1'b0;
    end
    step();
    obs_gid  = 32'(grant_id);
    obs_addr = txn_addr;
    chk("ready_onehot", 32'(req_ready), 32'(1 << exp_w));
    chk("grant_id", obs_gid, 32'(exp_w));
    chk("txn_addr_issue", obs_addr, exp_addr);
    chk("busy_issue", 32'(busy), 32'h1);
    chk("no_start_issue", 32'({start_read, start_write}), 32'h0);
    txn_done = issue_done;
    if (churn) begin
      req_valid = 4'($urandom_range(0, 15));
      req_write = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = $urandom();
    end
    step();
    txn_done = 1'b0;
    obs_sw = 32'(start_write);
    obs_sr = 32'(start_read);
    chk("start_write", obs_sw, 32'(exp_write));
    chk("start_read", obs_sr, 32'(!exp_write));
    chk("ready_clear", 32'(req_ready), 32'h0);
    chk("txn_addr_wait", txn_addr, exp_addr);
    chk("busy_wait", 32'(busy), 32'h1);
  endtask

  task automatic do_txn(input logic [3:0] vmask, input logic [3:0] wvec, input int delay,
                        input bit hold, input bit idle_done, input bit issue_done, input bit churn);
    grant_phase(vmask, wvec, hold, idle_done, issue_done, churn);
    repeat (delay) begin
      step();
      chk("wait_busy", 32'(busy), 32'h1);
      chk("wait_quiet", 32'({req_ready, start_read, start_write, timeout_err}), 32'h0);
      chk("wait_addr", txn_addr, exp_addr);
    end
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    chk("done_idle", 32'(busy), 32'h0);
    chk("done_quiet", 32'({req_ready, start_read, start_write, timeout_err}), 32'h0);
    exp_ptr = exp_w;
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic do_timeout(input logic [3:0] vmask, input bit done_at_term);
    grant_phase(vmask, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (15) begin
      step();
      chk("wd_quiet", 32'(timeout_err), 32'h0);
      chk("wd_busy", 32'(busy), 32'h1);
    end
    txn_done = done_at_term;
    step();
    txn_done = 1'b0;
    chk("wd_pulse", 32'(timeout_err), 32'(!done_at_term));
    chk("wd_idle", 32'(busy), 32'h0);
    exp_ptr = exp_w;
  endtask
`endif

  // ---------------- directed + random sequence ----------------
  initial begin
    areset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    txn_done  = 1'b0;
    exp_ptr   = 3;
    repeat (3) step();
    chk_all_zero("reset");
    req_valid = 4'b1111;
    txn_done  = 1'b1;
    step();
    chk("reset_no_grant", 32'(req_ready), 32'h0);
    txn_done = 1'b0;

    // Four requesters held valid: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = $urandom();
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] want;
      do_txn(4'b1111, 4'($urandom_range(0, 15)), 4, i > 0, 1'b0, 1'b0, 1'b0);
      want = exp_q.pop_front();
      chk("rr_order", obs_gid, want);
    end

    // Single read from requester 0 at address 0x4.
    req_addr[31:0] = 32'h4;
    do_txn(4'b0001, 4'b0000, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s_read_gid", obs_gid, 32'd0);
    chk("s_read_addr", obs_addr, 32'h4);
    chk("s_read_start", obs_sr, 32'h1);

    // Single write from requester 2 at address 0x40.
    req_addr[64 +: 32] = 32'h40;
    do_txn(4'b0100, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s_write_gid", obs_gid, 32'd2);
    chk("s_write_start", obs_sw, 32'h1);
    chk("s_write_no_read", obs_sr, 32'h0);

    // txn_done in IDLE and ISSUE is ignored; only the WAIT-state pulse completes.
    do_txn(4'b1010, 4'b0010, 5, 1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with request churn during ISSUE/WAIT.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = $urandom();
      do_txn(m, 4'($urandom_range(0, 15)), $urandom_range(0, 6), 1'b1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset in the middle of WAIT, then release with only requester 2 valid.
    grant_phase(4'b0011, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    areset    = 1'b1;
    req_valid = 4'b0100;
    #2;
    chk_all_zero("rst_async");
    step();
    step();
    chk_all_zero("rst_held");
    exp_ptr = 3;
    areset  = 1'b0;
    do_txn(4'b0100, 4'b0000, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_first_gid", obs_gid, 32'd2);

`ifdef SCHED_TIMEOUT_EN
    do_timeout(4'b1001, 1'b0);
    do_timeout(4'b0110, 1'b1);
    do_txn(4'b1111, 4'b0101, 1, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    // Without the watchdog a long WAIT never raises timeout_err.
    do_txn(4'b1001, 4'b0001, 20, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
